// File: rtl/vector_hazard_sched.sv
// ----------------------------------------------------------------------------
// vector_hazard_sched: register-write scoreboard, RAW/WAW bubble insertion and
// memory-wait back-end freeze for the five-stage vector pipeline.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vector_hazard_sched #(
   parameter int NREG    = 16,
   parameter int CW      = 2,
   parameter int MAXWAIT = 255,
   parameter int PCW     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [$clog2(NREG)-1:0] RA1D,
   input  logic [$clog2(NREG)-1:0] RA2D,
   input  logic                    UseRA1D,
   input  logic                    UseRA2D,
   input  logic                    RegWriteD,
   input  logic                    SPWriteD,
   input  logic [$clog2(NREG)-1:0] WA3D,
   input  logic                    RegWriteW,
   input  logic                    SPWriteW,
   input  logic [$clog2(NREG)-1:0] WA3W,
   input  logic [$clog2(NREG)-1:0] RA1W,
   input  logic                    MemAccessM,
   input  logic                    MemReadyM,
   output logic                    StallF,
   output logic                    StallD,
   output logic                    FlushE,
   output logic                    StallPipe,
   output logic                    MemErr,
   output logic [PCW-1:0]          HazardCycles,
   output logic [PCW-1:0]          MemWaitCycles
);

   localparam int AW = $clog2(NREG);
   localparam int WW = $clog2(MAXWAIT + 1);
   localparam logic [CW-1:0] PEND_MAX = '1;

   typedef enum logic [0:0] {S_RUN = 1'b0, S_WAIT = 1'b1} mem_state_t;

   logic [CW-1:0]   pend_q [NREG];
   logic [CW-1:0]   pend_d [NREG];
   logic [1:0]      inc    [NREG];
   logic [1:0]      dec    [NREG];
   logic [CW+1:0]   sum    [NREG];
   logic [CW+1:0]   diff   [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] sat_err;

   mem_state_t      state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic            memerr_q, memerr_d;
   logic [PCW-1:0]  haz_cnt_q, haz_cnt_d;
   logic [PCW-1:0]  mem_cnt_q, mem_cnt_d;

   logic haz, stall_pipe, issue, retire;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy[r] = (pend_q[r] != '0);
      end
   end

   // WAW is treated as a hazard so writers always retire in issue order
   assign haz = (UseRA1D & busy[RA1D]) | (UseRA2D & busy[RA2D]) |
                (RegWriteD & busy[WA3D]) | (SPWriteD & busy[RA1D]);

   assign stall_pipe = MemAccessM & ~MemReadyM;
   assign issue      = ~haz & ~stall_pipe;
   assign retire     = ~stall_pipe;

   assign StallPipe = stall_pipe;
   assign StallF    = haz | stall_pipe;
   assign StallD    = haz | stall_pipe;
   assign FlushE    = haz & ~stall_pipe;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         inc[r]     = 2'(issue & RegWriteD & (WA3D == AW'(r))) +
                      2'(issue & SPWriteD  & (RA1D == AW'(r)));
         dec[r]     = 2'(retire & RegWriteW & (WA3W == AW'(r))) +
                      2'(retire & SPWriteW  & (RA1W == AW'(r)));
         sum[r]     = {2'b00, pend_q[r]} + {{CW{1'b0}}, inc[r]};
         diff[r]    = sum[r] - {{CW{1'b0}}, dec[r]};
         pend_d[r]  = diff[r][CW-1:0];
         sat_err[r] = 1'b0;
         if (sum[r] < {{CW{1'b0}}, dec[r]}) begin
            pend_d[r]  = '0;
            sat_err[r] = 1'b1;
         end else if (diff[r] > {2'b00, PEND_MAX}) begin
            pend_d[r]  = PEND_MAX;
            sat_err[r] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      memerr_d = memerr_q;
      case (state_q)
         S_RUN: begin
            if (stall_pipe) begin
               state_d = S_WAIT;
               wcnt_d  = WW'(1);
            end
         end
         S_WAIT: begin
            if (MemReadyM) begin
               state_d = S_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q != WW'(MAXWAIT)) begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         default: begin
            state_d = S_RUN;
            wcnt_d  = '0;
         end
      endcase
      // wcnt counts completed wait cycles; the error latches once it hits the limit
      if (wcnt_d == WW'(MAXWAIT)) begin
         memerr_d = 1'b1;
      end
   end

   always_comb begin
      haz_cnt_d = haz_cnt_q;
      mem_cnt_d = mem_cnt_q;
      if (FlushE && (haz_cnt_q != '1)) begin
         haz_cnt_d = haz_cnt_q + PCW'(1);
      end
      if (stall_pipe && (mem_cnt_q != '1)) begin
         mem_cnt_d = mem_cnt_q + PCW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            pend_q[r] <= '0;
         end
         state_q   <= S_RUN;
         wcnt_q    <= '0;
         memerr_q  <= 1'b0;
         haz_cnt_q <= '0;
         mem_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            pend_q[r] <= pend_d[r];
         end
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         memerr_q  <= memerr_d;
         haz_cnt_q <= haz_cnt_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

   assign MemErr        = memerr_q;
   assign HazardCycles  = haz_cnt_q;
   assign MemWaitCycles = mem_cnt_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         assert (sat_err == '0);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_hazard_sched.sv
// ----------------------------------------------------------------------------
// tb_vector_hazard_sched: directed pipeline sequences with a queued scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vector_hazard_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  RA1D, RA2D, WA3D, WA3W, RA1W;
   logic        UseRA1D, UseRA2D, RegWriteD, SPWriteD, RegWriteW, SPWriteW;
   logic        MemAccessM, MemReadyM;
   logic        StallF, StallD, FlushE, StallPipe, MemErr;
   logic [15:0] HazardCycles, MemWaitCycles;

   always #5 clk = ~clk;

   vector_hazard_sched #(.NREG(16), .CW(2), .MAXWAIT(255), .PCW(16)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .UseRA1D(UseRA1D), .UseRA2D(UseRA2D),
      .RegWriteD(RegWriteD), .SPWriteD(SPWriteD), .WA3D(WA3D),
      .RegWriteW(RegWriteW), .SPWriteW(SPWriteW), .WA3W(WA3W), .RA1W(RA1W),
      .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallPipe(StallPipe),
      .MemErr(MemErr), .HazardCycles(HazardCycles), .MemWaitCycles(MemWaitCycles)
   );

   typedef struct packed {
      logic       rw, spw, mem, u1, u2;
      logic [3:0] wa3, ra1, ra2;
   } ins_t;

   typedef struct packed {
      logic        stall, flush, spipe, err;
      logic [15:0] hcnt, mcnt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   ins_t  e_s = '0, m_s = '0, w_s = '0;
   int    n_vec = 0, n_err = 0;
   int    hexp = 0, mexp = 0;
   logic  exp_err = 1'b0;

   function automatic ins_t mk(input logic rw, input logic spw, input logic mem,
                               input logic [3:0] wa3, input logic [3:0] ra1, input logic u1,
                               input logic [3:0] ra2, input logic u2);
      ins_t i;
      i.rw = rw; i.spw = spw; i.mem = mem; i.wa3 = wa3;
      i.ra1 = ra1; i.u1 = u1; i.ra2 = ra2; i.u2 = u2;
      return i;
   endfunction

   task automatic drive(input ins_t d, input logic mrdy);
      RA1D = d.ra1; RA2D = d.ra2; UseRA1D = d.u1; UseRA2D = d.u2;
      RegWriteD = d.rw; SPWriteD = d.spw; WA3D = d.wa3;
      RegWriteW = w_s.rw; SPWriteW = w_s.spw; WA3W = w_s.wa3; RA1W = w_s.ra1;
      MemAccessM = m_s.mem; MemReadyM = mrdy;
   endtask

   task automatic push(input string tag, input logic es, input logic ef, input logic ep);
      exp_t x;
      x.stall = es; x.flush = ef; x.spipe = ep; x.err = exp_err;
      x.hcnt = 16'(hexp); x.mcnt = 16'(mexp);
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   // one cycle: D instruction, memory ready, and hand-derived stall/flush/freeze
   task automatic step(input string tag, input ins_t d, input logic mrdy,
                       input logic es, input logic ef, input logic ep);
      @(negedge clk);
      reset = 1'b0;
      drive(d, mrdy);
      push(tag, es, ef, ep);
      hexp += int'(ef);
      mexp += int'(ep);
      @(posedge clk);
      if (!ep) begin
         w_s = m_s;
         m_s = e_s;
         e_s = es ? '0 : d;
      end
   endtask

   task automatic step_rst(input string tag, input ins_t d, input logic mrdy);
      @(negedge clk);
      reset = 1'b1;
      e_s = '0; m_s = '0; w_s = '0;
      hexp = 0; mexp = 0; exp_err = 1'b0;
      drive(d, mrdy);
      push(tag, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
   endtask

   task automatic drain();
      repeat (3) step("drain", '0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string tag, input string fld, input int got, input int want);
      if (got != want) begin
         n_err++;
         $display("FAIL %s %s: got %0d want %0d (t=%0t)", tag, fld, got, want, $time);
      end
   endtask

   initial begin
      exp_t  ex;
      string tg;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            tg = tag_q.pop_front();
            n_vec++;
            chk(tg, "StallD",        int'(StallD),        int'(ex.stall));
            chk(tg, "StallF",        int'(StallF),        int'(ex.stall));
            chk(tg, "FlushE",        int'(FlushE),        int'(ex.flush));
            chk(tg, "StallPipe",     int'(StallPipe),     int'(ex.spipe));
            chk(tg, "MemErr",        int'(MemErr),        int'(ex.err));
            chk(tg, "HazardCycles",  int'(HazardCycles),  int'(ex.hcnt));
            chk(tg, "MemWaitCycles", int'(MemWaitCycles), int'(ex.mcnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ins_t a, b, ld;
      reset = 1'b1;
      drive('0, 1'b1);
      step_rst("reset", '0, 1'b1);

      // independent stream: writes R1..R6, reads R9..R15
      for (int k = 1; k <= 6; k++) begin
         step("indep", mk(1, 0, 0, 4'(k), 4'(k + 8), 1, 4'(k + 9), 1), 1'b1, 0, 0, 0);
      end
      drain();

      // RAW on RA1: three bubbles, dependent issues in the fourth cycle
      a = mk(1, 0, 0, 4'd1, 4'd0, 0, 4'd0, 0);
      b = mk(1, 0, 0, 4'd2, 4'd1, 1, 4'd3, 1);
      step("raw1_prod", a, 1'b1, 0, 0, 0);
      repeat (3) step("raw1_bubble", b, 1'b1, 1, 1, 0);
      step("raw1_issue", b, 1'b1, 0, 0, 0);
      drain();

      // unused source is not a hazard
      step("nouse_prod", mk(1, 0, 0, 4'd5, 4'd0, 0, 4'd0, 0), 1'b1, 0, 0, 0);
      step("nouse_cons", mk(0, 0, 0, 4'd0, 4'd5, 0, 4'd5, 0), 1'b1, 0, 0, 0);
      drain();

      // RAW on RA2
      a = mk(1, 0, 0, 4'd3, 4'd0, 0, 4'd0, 0);
      b = mk(0, 0, 0, 4'd0, 4'd8, 1, 4'd3, 1);
      step("raw2_prod", a, 1'b1, 0, 0, 0);
      repeat (3) step("raw2_bubble", b, 1'b1, 1, 1, 0);
      step("raw2_issue", b, 1'b1, 0, 0, 0);
      drain();

      // WAW through RegWriteD
      a = mk(1, 0, 0, 4'd7, 4'd0, 0, 4'd0, 0);
      step("waw_prod", a, 1'b1, 0, 0, 0);
      repeat (3) step("waw_bubble", a, 1'b1, 1, 1, 0);
      step("waw_issue", a, 1'b1, 0, 0, 0);
      drain();

      // WAW through SPWriteD on RA1
      a = mk(1, 0, 0, 4'd6, 4'd0, 0, 4'd0, 0);
      b = mk(0, 1, 0, 4'd0, 4'd6, 0, 4'd0, 0);
      step("spw_prod", a, 1'b1, 0, 0, 0);
      repeat (3) step("spw_bubble", b, 1'b1, 1, 1, 0);
      step("spw_issue", b, 1'b1, 0, 0, 0);
      drain();

      // load waits 5 cycles; the producer sitting in W must not retire meanwhile
      a  = mk(1, 0, 0, 4'd10, 4'd0, 0, 4'd0, 0);
      ld = mk(1, 0, 1, 4'd9, 4'd0, 0, 4'd0, 0);
      b  = mk(1, 0, 0, 4'd12, 4'd10, 1, 4'd0, 0);
      step("ld_prod", a, 1'b1, 0, 0, 0);
      step("ld_issue", ld, 1'b1, 0, 0, 0);
      step("ld_haz", b, 1'b1, 1, 1, 0);
      repeat (5) step("ld_wait", b, 1'b0, 1, 0, 1);
      step("ld_ready", b, 1'b1, 1, 1, 0);
      step("ld_dep_issue", b, 1'b1, 0, 0, 0);
      drain();

      // WA3D == RA1D with both enables: double count retired together in W
      a = mk(1, 1, 0, 4'd4, 4'd4, 0, 4'd0, 0);
      b = mk(0, 0, 0, 4'd0, 4'd4, 1, 4'd0, 0);
      step("dbl_issue", a, 1'b1, 0, 0, 0);
      repeat (3) step("dbl_bubble", b, 1'b1, 1, 1, 0);
      step("dbl_dep_issue", b, 1'b1, 0, 0, 0);
      drain();

      // memory timeout: error latched after the 255th wait cycle, sticky
      step("to_load", mk(1, 0, 1, 4'd13, 4'd0, 0, 4'd0, 0), 1'b1, 0, 0, 0);
      step("to_e", '0, 1'b1, 0, 0, 0);
      for (int k = 1; k <= 300; k++) begin
         exp_err = (k >= 256);
         step("to_wait", '0, 1'b0, 1, 0, 1);
      end
      step("to_ready", '0, 1'b1, 0, 0, 0);
      drain();

      // asynchronous reset with pend[5]=2 and the FSM waiting
      a  = mk(1, 1, 0, 4'd5, 4'd5, 0, 4'd0, 0);
      ld = mk(1, 0, 1, 4'd11, 4'd0, 0, 4'd0, 0);
      b  = mk(0, 0, 0, 4'd0, 4'd5, 1, 4'd0, 0);
      step("rf_sp", a, 1'b1, 0, 0, 0);
      step("rf_ld", ld, 1'b1, 0, 0, 0);
      step("rf_haz", b, 1'b1, 1, 1, 0);
      step("rf_wait", b, 1'b0, 1, 0, 1);
      step("rf_wait2", b, 1'b0, 1, 0, 1);
      step_rst("rf_reset", b, 1'b0);
      step("rf_after", b, 1'b1, 0, 0, 0);
      drain();

      repeat (2) @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vector_hazard_sched.md
# vector_hazard_sched

Pipeline scheduler for the five-stage vector CPU (F/D/E/M/W). It keeps a scoreboard of in-flight register writes to detect read-after-write hazards at Decode and inserts bubbles into Execute until the producing instruction has retired. It also freezes the back end (E/M/W) while a data-memory access in M waits for the memory's ready handshake. Segment registers consume its stall and flush outputs; the block has no forwarding paths.

## Interface
- NREG, 16, number of architectural vector registers; index width is $clog2(NREG).
- CW, 2, width of each scoreboard pending counter; it holds up to 3 in-flight writers (E, M, W).
- MAXWAIT, 255, number of memory-wait cycles before MemErr is raised.
- PCW, 16, width of the saturating performance counters.

- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- RA1D, RA2D  in  4  Decode source indices (RA2D is taken after the RegSrc mux).
- UseRA1D, UseRA2D  in  1  the Decode instruction actually reads that source.
- RegWriteD, SPWriteD  in  1  the Decode instruction writes WA3D, and/or writes RA1D through the WD1 port.
- WA3D  in  4  Decode destination index.
- RegWriteW, SPWriteW  in  1  Write-back write enables.
- WA3W, RA1W  in  4  Write-back destination indices.
- MemAccessM  in  1  MemWriteM | MemtoRegM.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD  out  1  hold the PC and the IF/ID register.
- FlushE  out  1  load a bubble (all control bits 0) into ID/EX.
- StallPipe  out  1  hold ID/EX, EX/MEM and MEM/WB, and suppress the regfile write.
- MemErr  out  1  sticky memory-timeout error.
- HazardCycles, MemWaitCycles  out  PCW  saturating counts of hazard bubbles and memory-wait cycles.

## Operation
- Scoreboard: pend[r] is a CW-bit counter per register. A register is busy when pend[r] != 0.
- Issue (Decode to Execute) occurs when StallD=0 and StallPipe=0.
  - pend[WA3D] += RegWriteD.
  - pend[RA1D] += SPWriteD.
  - If WA3D == RA1D and both enables are set, that register gets +2.
- Retire occurs when StallPipe=0.
  - pend[WA3W] -= RegWriteW.
  - pend[RA1W] -= SPWriteW.
  - The same double-count rule applies when WA3W == RA1W.
- Issue and retire on the same register in one cycle apply the net change.
- Counters never wrap. If a counter would overflow or underflow, it saturates and, in simulation only, an assertion fires.
- Hazard: haz = (UseRA1D & busy[RA1D]) | (UseRA2D & busy[RA2D]). WAW is also a hazard: (RegWriteD & busy[WA3D]) | (SPWriteD & busy[RA1D]). This keeps retire order trivially correct.
- Stall and flush outputs:
  - StallF = StallD = haz | StallPipe.
  - FlushE = haz & ~StallPipe.
  - StallPipe = MemAccessM & ~MemReadyM.
- Memory FSM:
  - RUN to WAIT when MemAccessM & ~MemReadyM.
  - WAIT to RUN when MemReadyM.
  - In WAIT, wcnt increments each cycle. When wcnt reaches MAXWAIT, MemErr is set (sticky) and the FSM stays in WAIT.
  - wcnt clears on entry to RUN.
- Performance counters saturate at 2^PCW-1.
  - HazardCycles increments on every FlushE=1 cycle.
  - MemWaitCycles increments on every StallPipe=1 cycle.

## Timing
- Reset (asynchronous): every pend is 0, FSM is RUN, wcnt=0, MemErr=0, and both counters are 0.
  - Stall and flush outputs follow the combinational equations, so with the pipe empty they are 0.
- Stall and flush outputs are combinational from registered state plus the current D/M inputs. There are no registered outputs except MemErr and the counters.
- Regfile writes at the rising edge ending the W cycle, so a dependent instruction leaves D on the cycle after the producer's W cycle. For back-to-back dependents this costs 3 bubbles.
- StallPipe has priority: no bubble is inserted and no scoreboard update happens while it is high.
- If reset is asserted mid-operation, the scoreboard clears immediately. The segment registers also reset, so no stale retire can arrive.

## Test plan
- Reset, then an independent stream (R1 to R2 reads R3, and so on) -> StallD=0 every cycle, HazardCycles=0.
- ADD R1 then ADD R2,R1,R3 back-to-back -> FlushE=1 for exactly 3 cycles, pend[1] goes 1,1,1,0, and the dependent issues in cycle 4.
- Load with MemReadyM held low for 5 cycles -> StallPipe=1 for 5 cycles, MemWaitCycles=5, pend unchanged, FSM returns to RUN.
- Instruction with RegWriteD=SPWriteD=1 and WA3D=RA1D=4 -> pend[4]=2 after issue and 0 only after its W retire.
- MemReadyM held low for 300 cycles with MAXWAIT=255 -> MemErr rises on wait cycle 255 and stays high until reset.
- Reset asserted while pend[5]=2 and in WAIT -> all pend=0, FSM=RUN, MemErr=0 asynchronously, before the next edge.
